// File: rtl/regfile_pkg.sv
// Shared types and sizing for the LEGv8 register file.
// Word and register-address types are used by the top and its storage cells.
package regfile_pkg;

  localparam int WIDTH    = 64;
  localparam int NREGS    = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef logic [63:0] word_t;
  typedef logic [4:0]  reg_addr_t;

endpackage

// File: rtl/register64_en.sv
// One enabled data register; the feedback mux holds q whenever en is low.
module register64_en
  import regfile_pkg::*;
#(
  parameter int W = regfile_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= en ? d : q;
  end

endmodule

// File: rtl/regfile.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one clocked
// write port, X31 (XZR) reads as zero and discards writes.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH    = regfile_pkg::WIDTH,
  parameter int NREGS    = regfile_pkg::NREGS,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  function automatic logic [NREGS-1:0] decoder_5to32(input logic en,
                                                     input logic [ADDR_W-1:0] addr);
    logic [NREGS-1:0] onehot;
    onehot = '0;
    onehot[addr] = en;
    return onehot;
  endfunction

  function automatic logic [WIDTH-1:0] mux2(input logic s,
                                            input logic [WIDTH-1:0] a0,
                                            input logic [WIDTH-1:0] a1);
    return s ? a1 : a0;
  endfunction

  // Five levels of 2:1 stages, address bit 0 selecting at the leaves.
  // Each stage overwrites the lower half in place; index i only reads 2i and
  // 2i+1, which have not been overwritten yet within that level.
  function automatic logic [WIDTH-1:0] mux32_1(input logic [WIDTH-1:0] regs [NREGS],
                                               input logic [ADDR_W-1:0] sel);
    logic [WIDTH-1:0] stage [NREGS];
    stage = regs;
    for (int lvl = 0; lvl < ADDR_W; lvl++) begin
      for (int i = 0; i < (NREGS >> (lvl + 1)); i++) begin
        stage[i] = mux2(sel[lvl], stage[2*i], stage[2*i+1]);
      end
    end
    return stage[0];
  endfunction

  logic [NREGS-1:0] write_en;
  logic [WIDTH-1:0] regs [NREGS];

  always_comb begin
    write_en = decoder_5to32(RegWrite, WriteRegister);
    write_en[ZERO_REG] = 1'b0;
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (gi == ZERO_REG) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_store
      register64_en #(.W(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (write_en[gi]),
        .d     (WriteData),
        .q     (regs[gi])
      );
    end
  end

  // No write bypass: a read of the register being written sees the old value.
  always_comb begin
    ReadData1 = mux32_1(regs, ReadRegister1);
    ReadData2 = mux32_1(regs, ReadRegister2);
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for the regfile block.
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [63:0] WriteData;
  logic [63:0] ReadData1, ReadData2;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] PATTERN = 64'h0101_0101_0101_0101;

  regfile dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write in the low phase, let one rising edge take it, then release.
  task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
    @(negedge clk);
    RegWrite      = 1'b1;
    WriteRegister = addr;
    WriteData     = data;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [63:0] e1, input logic [63:0] e2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
    chk($sformatf("%s rd1[x%0d]", tag, a1), ReadData1, e1);
    chk($sformatf("%s rd2[x%0d]", tag, a2), ReadData2, e2);
  endtask

  initial begin
    reset = 1'b1;
    RegWrite = 1'b0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    WriteRegister = 5'd0;
    WriteData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    read_pair("init", 5'd0, 5'd30, 64'd0, 64'd0);

    // 1. Async reset mid-cycle after a preload
    do_write(5'd5, 64'hDEAD);
    read_pair("preload", 5'd5, 5'd5, 64'hDEAD, 64'hDEAD);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset x5", ReadData1, 64'd0);
    RegWrite = 1'b1;
    WriteRegister = 5'd6;
    WriteData = 64'hABC;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    read_pair("edge_in_reset", 5'd6, 5'd6, 64'd0, 64'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_pair("reset_all", 5'(i), 5'(31 - i), 64'd0, 64'd0);
    end

    // 2. Basic write/read
    do_write(5'd7, 64'd64357);
    read_pair("basic", 5'd7, 5'd8, 64'd64357, 64'd0);

    // 3. Write-enable gating
    @(negedge clk);
    RegWrite = 1'b0;
    WriteRegister = 5'd3;
    WriteData = 64'd26000;
    @(posedge clk);
    #1;
    read_pair("we_gate", 5'd3, 5'd7, 64'd0, 64'd64357);

    // 4. Zero register
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd31;
    WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    read_pair("xzr_before", 5'd31, 5'd31, 64'd0, 64'd0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    read_pair("xzr_after", 5'd31, 5'd31, 64'd0, 64'd0);

    // 5. Read-during-write returns old value until the edge
    do_write(5'd9, 64'd1);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd9;
    WriteData = 64'd2;
    read_pair("rdw_before", 5'd9, 5'd9, 64'd1, 64'd1);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    read_pair("rdw_after", 5'd9, 5'd9, 64'd2, 64'd2);

    // 6. Full sweep with distinct addresses on each port
    for (int i = 0; i < 31; i++) begin
      do_write(5'(i), 64'(i) * PATTERN);
    end
    for (int i = 0; i < 31; i++) begin
      read_pair("sweep", 5'(i), 5'(30 - i), 64'(i) * PATTERN, 64'(30 - i) * PATTERN);
    end
    read_pair("sweep_xzr", 5'd31, 5'd1, 64'd0, PATTERN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: bench did not complete within time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 64-bit LEGv8 register file for the single-cycle datapath.
- Sits directly upstream of the 64-bit 2:1 operand muxes: ReadData2 feeds the ALUSrc mux input 0, and ReadData1 feeds the ALU A input.
- It consumes the MemToReg mux output as WriteData.
- Two combinational read ports and one clocked write port. X31 (XZR) is hardwired to zero.

Parameters:
- WIDTH, 64, data width of each register and port.
- NREGS, 32, number of architectural registers (X0..X31).
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  input  1  datapath clock; writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- RegWrite  input  1  write enable for the current cycle.
- ReadRegister1  input  5  read port 1 address (Rn).
- ReadRegister2  input  5  read port 2 address (Rm or Rd, chosen by the Reg2Loc mux upstream).
- WriteRegister  input  5  write address (Rd).
- WriteData  input  64  data from the MemToReg mux.
- ReadData1  output  64  contents of ReadRegister1.
- ReadData2  output  64  contents of ReadRegister2.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; its assertion takes effect without waiting for a clock edge.
- Reset values:
  - While reset=1, all 32 registers are 0, so ReadData1 = ReadData2 = 0 after the read-path delay.
  - A clk edge during reset does not write.
  - Reset deasserting mid-cycle leaves registers at 0 until the next qualifying edge.
- Write:
  - On posedge clk with reset=0 and RegWrite=1, register[WriteRegister] <= WriteData.
  - All other registers hold.
  - RegWrite=0 means no register changes.
- Decode: a 5:32 decoder gated by RegWrite selects exactly one register enable. Register 31's enable is tied off, so writes to X31 are discarded.
- Storage: each register is 64 D flip-flops. Each bit holds its value via a feedback mux, d = en ? WriteData : q.
- Read:
  - Purely combinational, with no clock latency.
  - Each port is a 32:1 x 64-bit mux tree built from 2:1 stages using address bits [0]..[4].
  - X31's mux input is constant 0.
- Read-during-write: a read of the register being written returns the OLD value until the clock edge. The new value appears after the edge plus the read-path delay. There is no internal bypass.
- Simultaneous events:
  - Both read ports may address the same register; both return identical data.
  - A write to X31 together with a read of X31 returns 0.
- Timing:
  - Gate primitives carry 50ps delay, matching the rest of the datapath.
  - Read path worst case is 5 mux levels (about 0.75 ns incl. select inversion).
  - The write-to-read-valid delay must fit within the processor clock period.
- X-safety: an unknown RegWrite or WriteRegister during a clock edge is a bench error. The RTL need not mask it.

Decomposition:
- Shared package (regfile_pkg):
  - localparams WIDTH=64, NREGS=32, ADDR_W=5, ZERO_REG=31.
  - typedef word_t = logic [63:0].
  - typedef reg_addr_t = logic [4:0].
- Sub-module register64_en: one 64-bit enabled register, with ports clk, reset, en, d[63:0], q[63:0].
  - Instantiated 31 times (X0..X30) in a generate loop.
- The decoder_5to32 and mux32_1 trees are in-file helpers.
  - mux32_1 reuses the existing 64-bit 2:1 mux cell (31 instances per read port).

Test Plan:
1. Reset: assert reset=1 asynchronously mid-cycle, after preloading X5=64'hDEAD -> ReadData1 (addr 5) = 0 before any clk edge; all 31 registers read 0.
2. Basic write/read: RegWrite=1, WriteRegister=7, WriteData=64'd64357, one edge, then RegWrite=0 -> ReadRegister1=7 gives 64357; ReadRegister2=8 gives 0.
3. Write-enable gating: RegWrite=0, WriteRegister=3, WriteData=64'd26000, one edge -> X3 remains 0.
4. Zero register: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF -> both ports reading 31 give 0 before and after the edge.
5. Read-during-write: X9 holds 64'd1; write 64'd2 to X9 while ReadRegister1=9 -> 1 before the edge, 2 after the edge plus read delay.
6. Full sweep: write i*64'h0101_0101_0101_0101 to X0..X30, then read each on both ports with different addresses -> every value matches, with no cross-talk between registers.
